// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - fetch-to-decode instruction queue; optional back-pressure counter under INST_BUFFER_PERF_EN
module inst_buffer #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int PC_WIDTH     = 32,
  parameter int PC_STEP      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FETCH_WIDTH-1:0]               in_mask,
  input  logic [FETCH_WIDTH*32-1:0]            in_inst,
  input  logic [PC_WIDTH-1:0]                  in_pc,
  output logic [DECODE_WIDTH-1:0]              out_valid,
  output logic [DECODE_WIDTH*32-1:0]           out_inst,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0]     out_pc,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]    out_take,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic [31:0]                          perf_full_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]         inst_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic                enq_fire;
  logic [CNT_W-1:0]    enq_n;
  logic [CNT_W-1:0]    deq_n;

  // Ready looks only at the registered occupancy; a same-cycle dequeue is not credited
  assign in_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enq_fire = in_valid && in_ready && !flush;

  // Number of slots in the offered batch (mask is a thermometer code)
  always_comb begin
    enq_n = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      enq_n = enq_n + CNT_W'(in_mask[j]);
    end
  end

  // Clamp the decode request to what is actually present and to the lane count
  always_comb begin
    deq_n = CNT_W'(out_take);
    if (deq_n > count) deq_n = count;
    if (deq_n > CNT_W'(DECODE_WIDTH)) deq_n = CNT_W'(DECODE_WIDTH);
  end

  // Head/tail pointers wrap naturally at DEPTH; flush overrides any enqueue/dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + PTR_W'(deq_n);
      if (enq_fire) tail <= tail + PTR_W'(enq_n);
      count <= count + (enq_fire ? enq_n : '0) - deq_n;
    end
  end

  // Write accepted slots at consecutive entries from tail, each tagged with its own PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (enq_fire) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CNT_W'(j) < enq_n) begin
          inst_mem[tail + PTR_W'(j)] <= in_inst[j*32 +: 32];
          pc_mem[tail + PTR_W'(j)]   <= in_pc + PC_WIDTH'(j * PC_STEP);
        end
      end
    end
  end

  // Present the oldest entries starting at head; lane validity is a thermometer of count
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      out_valid[i]                   = (CNT_W'(i) < count);
      out_inst[i*32 +: 32]           = inst_mem[head + PTR_W'(i)];
      out_pc[i*PC_WIDTH +: PC_WIDTH] = pc_mem[head + PTR_W'(i)];
    end
  end

`ifdef INST_BUFFER_PERF_EN
  logic [31:0] perf_q;

  // Count stalled fetch cycles, saturating; survives flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (in_valid && !in_ready && !flush && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_full_cycles = perf_q;
`else
  assign perf_full_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard bench for inst_buffer
module tb_inst_buffer;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_mask;
  logic [127:0] in_inst;
  logic [31:0]  in_pc;
  logic [3:0]   out_valid;
  logic [127:0] out_inst;
  logic [127:0] out_pc;
  logic [2:0]   out_take;
  logic [4:0]   count;
  logic [31:0]  perf_full_cycles;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   perf_exp = 0;
  int   tests = 0;
  int   fails = 0;

  inst_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_mask          (in_mask),
    .in_inst          (in_inst),
    .in_pc            (in_pc),
    .out_valid        (out_valid),
    .out_inst         (out_inst),
    .out_pc           (out_pc),
    .out_take         (out_take),
    .count            (count),
    .perf_full_cycles (perf_full_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] m, input logic [31:0] pc,
                       input logic [2:0] take, input logic fl);
    in_valid = v;
    in_mask  = m;
    in_pc    = pc;
    out_take = take;
    flush    = fl;
    for (int j = 0; j < 4; j++) in_inst[j*32 +: 32] = $urandom;
  endtask

  task automatic check_all();
    logic [3:0] ev;
    int pexp;
    ev = '0;
    for (int i = 0; i < 4; i++) if (i < q.size()) ev[i] = 1'b1;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'((16 - q.size()) >= 4));
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      chk($sformatf("out_inst[%0d]", i), 64'(out_inst[i*32 +: 32]), 64'(q[i].inst));
      chk($sformatf("out_pc[%0d]", i), 64'(out_pc[i*32 +: 32]), 64'(q[i].pc));
    end
`ifdef INST_BUFFER_PERF_EN
    pexp = perf_exp;
`else
    pexp = 0;
`endif
    chk("perf_full_cycles", 64'(perf_full_cycles), 64'(pexp));
  endtask

  // Predict the effect of the current inputs, clock once, then compare
  task automatic step();
    int k;
    bit rdy;
    rdy = (16 - q.size()) >= 4;
    if (in_valid && !rdy && !flush) perf_exp++;
    if (flush) begin
      q.delete();
    end else begin
      k = int'(out_take);
      if (k > q.size()) k = q.size();
      if (k > 4) k = 4;
      repeat (k) void'(q.pop_front());
      if (in_valid && rdy) begin
        for (int j = 0; j < $countones(in_mask); j++) begin
          ent_t e;
          e.inst = in_inst[j*32 +: 32];
          e.pc   = in_pc + j;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_out_inst", out_inst[63:0], 64'h0);
    chk("reset_out_pc", out_pc[63:0], 64'h0);
    rst_n = 1'b1;

    // single full batch
    drive(1'b1, 4'b1111, 32'h100, 3'd0, 1'b0);
    in_inst = {32'hD, 32'hC, 32'hB, 32'hA};
    step();
    chk("first_count", 64'(count), 64'd4);
    chk("first_valid", 64'(out_valid), 64'hF);
    chk("first_pc0", 64'(out_pc[31:0]), 64'h100);
    chk("first_pc3", 64'(out_pc[127:96]), 64'h103);
    chk("first_inst0", 64'(out_inst[31:0]), 64'hA);

    // fill to 13
    drive(1'b1, 4'b1111, 32'h104, 3'd0, 1'b0); step();
    drive(1'b1, 4'b1111, 32'h108, 3'd0, 1'b0); step();
    drive(1'b1, 4'b0001, 32'h10C, 3'd0, 1'b0); step();
    chk("full_count", 64'(count), 64'd13);
    chk("full_ready", 64'(in_ready), 64'd0);

    // back-pressured offers must not write
    drive(1'b1, 4'b1111, 32'h110, 3'd0, 1'b0);
    repeat (5) step();
    chk("stall_count", 64'(count), 64'd13);

    // drain, including over-asking at count 1 and asking at empty
    drive(1'b0, 4'b0000, 32'h0, 3'd4, 1'b0);
    repeat (5) step();
    chk("drained_count", 64'(count), 64'd0);

    // partial batch with simultaneous dequeue
    drive(1'b1, 4'b0011, 32'h180, 3'd0, 1'b0); step();
    drive(1'b1, 4'b0011, 32'h200, 3'd2, 1'b0); step();
    chk("partial_count", 64'(count), 64'd2);
    chk("partial_pc0", 64'(out_pc[31:0]), 64'h200);
    chk("partial_pc1", 64'(out_pc[63:32]), 64'h201);
    drive(1'b0, 4'b0000, 32'h0, 3'd2, 1'b0); step();

    // wrap across entry 15 -> 0
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, 4'b1111, 32'h300 + 32'(4 * b), 3'd4, 1'b0);
      step();
      chk("wrap_count", 64'(count), 64'd4);
    end

    // grow to 8, then flush with enqueue and dequeue pending
    drive(1'b1, 4'b1111, 32'h320, 3'd0, 1'b0); step();
    chk("pre_flush_count", 64'(count), 64'd8);
    drive(1'b1, 4'b1111, 32'h400, 3'd3, 1'b1); step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);

    // asynchronous reset mid-operation
    drive(1'b1, 4'b1111, 32'h500, 3'd0, 1'b0); step();
    drive(1'b1, 4'b0011, 32'h504, 3'd0, 1'b0); step();
    chk("pre_reset_count", 64'(count), 64'd6);
    drive(1'b0, 4'b0000, 32'h0, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_perf", 64'(perf_full_cycles), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd1);
    q.delete();
    perf_exp = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // operational again after reset
    drive(1'b1, 4'b0111, 32'h600, 3'd0, 1'b0); step();
    drive(1'b0, 4'b0000, 32'h0, 3'd1, 1'b0); step();
    chk("post_reset_count", 64'(count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
